// File: rtl/branch_predictor.sv
// Branch prediction unit: 2-bit pattern table (bimodal or gshare indexed),
// global branch history register and a direct-mapped BTB. Lookups and
// resolution are combinational; training happens on the rising clock edge.
module branch_predictor #(
   parameter int DBITS        = 32,
   parameter int PT_IDX_BITS  = 8,
   parameter int BHR_BITS     = 8,
   parameter int BTB_IDX_BITS = 4,
   parameter int GSHARE       = 1
) (
   input  logic                clk,
   input  logic                reset,
   input  logic [DBITS-1:0]    fe_pc,
   output logic                fe_pred_taken,
   output logic [DBITS-1:0]    fe_pred_pc,
   input  logic                upd_valid,
   input  logic [DBITS-1:0]    upd_pc,
   input  logic                upd_is_cond,
   input  logic                upd_is_jump,
   input  logic                upd_taken,
   input  logic [DBITS-1:0]    upd_target,
   input  logic                upd_pred_taken,
   input  logic [DBITS-1:0]    upd_pred_pc,
   output logic                mispredict,
   output logic [DBITS-1:0]    redirect_pc,
   output logic [BHR_BITS-1:0] bhr_out,
   output logic [31:0]         stat_branches,
   output logic [31:0]         stat_mispredicts
);

   localparam int PT_SIZE  = 1 << PT_IDX_BITS;
   localparam int BTB_SIZE = 1 << BTB_IDX_BITS;
   localparam int TAG_BITS = DBITS - BTB_IDX_BITS - 2;

   // Prediction state
   logic [1:0]          pt [PT_SIZE];
   logic [BHR_BITS-1:0] bhr;
   logic [BTB_SIZE-1:0] btb_valid;
   logic                btb_is_jump [BTB_SIZE];
   logic [TAG_BITS-1:0] btb_tag     [BTB_SIZE];
   logic [DBITS-1:0]    btb_target  [BTB_SIZE];

   // Lookup-side decode
   logic [PT_IDX_BITS-1:0]  fe_pt_idx;
   logic [BTB_IDX_BITS-1:0] fe_btb_idx;
   logic [TAG_BITS-1:0]     fe_tag;
   logic                    fe_hit;

   // Update-side decode
   logic [PT_IDX_BITS-1:0]  upd_pt_idx;
   logic [BTB_IDX_BITS-1:0] upd_btb_idx;
   logic [TAG_BITS-1:0]     upd_tag;
   logic [DBITS-1:0]        upd_next;
   logic [1:0]              pt_cur;
   logic [1:0]              pt_next;
   logic [BHR_BITS-1:0]     bhr_next;
   logic                    pt_write;
   logic                    btb_write;

   // The prediction carried down the pipe is implied by upd_pred_pc, so the
   // taken bit itself is not needed to decide a mispredict.
   logic unused_inputs;
   assign unused_inputs = upd_pred_taken;

   // Pattern-table index: word index, optionally folded with global history.
   function automatic logic [PT_IDX_BITS-1:0] pt_index(input logic [DBITS-1:0]    pc,
                                                       input logic [BHR_BITS-1:0] hist);
      logic [PT_IDX_BITS-1:0] widx;
      logic [PT_IDX_BITS-1:0] hist_ext;
      widx     = pc[PT_IDX_BITS+1:2];
      hist_ext = PT_IDX_BITS'(hist);
      if (GSHARE != 0) pt_index = widx ^ hist_ext;
      else             pt_index = widx;
   endfunction

   // History shift; a one-bit history simply holds the last outcome.
   generate
      if (BHR_BITS == 1) begin : g_bhr_one
         assign bhr_next = upd_taken;
      end else begin : g_bhr_many
         assign bhr_next = {bhr[BHR_BITS-2:0], upd_taken};
      end
   endgenerate

   // Fetch-side prediction from current table contents (no update bypass)
   always_comb begin
      fe_pt_idx     = pt_index(fe_pc, bhr);
      fe_btb_idx    = fe_pc[BTB_IDX_BITS+1:2];
      fe_tag        = fe_pc[DBITS-1:BTB_IDX_BITS+2];
      fe_hit        = btb_valid[fe_btb_idx] && (btb_tag[fe_btb_idx] == fe_tag);
      fe_pred_taken = fe_hit && (btb_is_jump[fe_btb_idx] || pt[fe_pt_idx][1]);
      fe_pred_pc    = fe_pred_taken ? btb_target[fe_btb_idx] : fe_pc + DBITS'(4);
   end

   // Resolution, counter saturation and write enables for this cycle's update
   always_comb begin
      upd_pt_idx  = pt_index(upd_pc, bhr);
      upd_btb_idx = upd_pc[BTB_IDX_BITS+1:2];
      upd_tag     = upd_pc[DBITS-1:BTB_IDX_BITS+2];
      upd_next    = upd_taken ? upd_target : upd_pc + DBITS'(4);
      mispredict  = upd_valid && (upd_next != upd_pred_pc);
      redirect_pc = upd_next;
      pt_cur      = pt[upd_pt_idx];
      pt_next     = pt_cur;
      if (upd_taken) begin
         if (pt_cur != 2'b11) pt_next = pt_cur + 2'b01;
      end else begin
         if (pt_cur != 2'b00) pt_next = pt_cur - 2'b01;
      end
      pt_write  = upd_valid && upd_is_cond;
      btb_write = upd_valid && upd_taken;
   end

   // Pattern table: all counters return to weakly not-taken on reset
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < PT_SIZE; i++) pt[i] <= 2'b01;
      end else if (pt_write) begin
         pt[upd_pt_idx] <= pt_next;
      end
   end

   // Global history advances only on conditional branches
   always_ff @(posedge clk or posedge reset) begin
      if (reset)         bhr <= '0;
      else if (pt_write) bhr <= bhr_next;
   end

   // BTB valid bits: cleared on reset, set by any taken resolution
   always_ff @(posedge clk or posedge reset) begin
      if (reset)          btb_valid <= '0;
      else if (btb_write) btb_valid[upd_btb_idx] <= 1'b1;
   end

   // BTB payload needs no reset; it is qualified by the valid bit
   always_ff @(posedge clk) begin
      if (btb_write && !reset) begin
         btb_is_jump[upd_btb_idx] <= upd_is_jump;
         btb_tag[upd_btb_idx]     <= upd_tag;
         btb_target[upd_btb_idx]  <= upd_target;
      end
   end

   // Statistics counters, wrapping modulo 2^32
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         stat_branches    <= '0;
         stat_mispredicts <= '0;
      end else if (upd_valid) begin
         stat_branches <= stat_branches + 32'd1;
         if (mispredict) stat_mispredicts <= stat_mispredicts + 32'd1;
      end
   end

   assign bhr_out = bhr;

endmodule

// File: tb/tb_branch_predictor.sv
// Directed bench: one bimodal instance (default sizes) and one gshare
// instance with a 2-bit history, both driven by the same update stream.
module tb_branch_predictor;

   logic        clk = 1'b0;
   logic        reset;
   logic [31:0] fe_pc;
   logic        upd_valid, upd_is_cond, upd_is_jump, upd_taken, upd_pred_taken;
   logic [31:0] upd_pc, upd_target, upd_pred_pc;

   logic        b_pred_taken, b_mispredict;
   logic [31:0] b_pred_pc, b_redirect, b_stat_br, b_stat_mis;
   logic [7:0]  b_bhr;
   logic        g_pred_taken, g_mispredict;
   logic [31:0] g_pred_pc, g_redirect, g_stat_br, g_stat_mis;
   logic [1:0]  g_bhr;

   int n_checks = 0;
   int n_errors = 0;

   always #5 clk = ~clk;

   branch_predictor #(.DBITS(32), .PT_IDX_BITS(8), .BHR_BITS(8), .BTB_IDX_BITS(4), .GSHARE(0)) u_bim (
      .clk(clk), .reset(reset), .fe_pc(fe_pc),
      .fe_pred_taken(b_pred_taken), .fe_pred_pc(b_pred_pc),
      .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_is_cond(upd_is_cond),
      .upd_is_jump(upd_is_jump), .upd_taken(upd_taken), .upd_target(upd_target),
      .upd_pred_taken(upd_pred_taken), .upd_pred_pc(upd_pred_pc),
      .mispredict(b_mispredict), .redirect_pc(b_redirect), .bhr_out(b_bhr),
      .stat_branches(b_stat_br), .stat_mispredicts(b_stat_mis));

   branch_predictor #(.DBITS(32), .PT_IDX_BITS(8), .BHR_BITS(2), .BTB_IDX_BITS(4), .GSHARE(1)) u_gsh (
      .clk(clk), .reset(reset), .fe_pc(fe_pc),
      .fe_pred_taken(g_pred_taken), .fe_pred_pc(g_pred_pc),
      .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_is_cond(upd_is_cond),
      .upd_is_jump(upd_is_jump), .upd_taken(upd_taken), .upd_target(upd_target),
      .upd_pred_taken(upd_pred_taken), .upd_pred_pc(upd_pred_pc),
      .mispredict(g_mispredict), .redirect_pc(g_redirect), .bhr_out(g_bhr),
      .stat_branches(g_stat_br), .stat_mispredicts(g_stat_mis));

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // One resolution update: check the combinational outputs, then clock it in.
   task automatic upd(input string tag, input logic [31:0] pc, input logic cond,
                      input logic taken, input logic [31:0] target,
                      input logic [31:0] pred_pc, input logic exp_mis,
                      input logic [31:0] exp_redirect);
      upd_valid      = 1'b1;
      upd_pc         = pc;
      upd_is_cond    = cond;
      upd_is_jump    = !cond;
      upd_taken      = taken;
      upd_target     = target;
      upd_pred_pc    = pred_pc;
      upd_pred_taken = (pred_pc != pc + 32'd4);
      #1;
      $display("upd %s pc=%h taken=%0d pred_pc=%h mis=%0d redirect=%h",
               tag, pc, taken, pred_pc, b_mispredict, b_redirect);
      check({tag, ".mis"}, {31'd0, b_mispredict}, {31'd0, exp_mis});
      check({tag, ".redir"}, b_redirect, exp_redirect);
      @(posedge clk);
      #1;
      upd_valid = 1'b0;
   endtask

   // Alternating pattern for the gshare phase, hand-traced from counters at 01
   logic        g_taken [7] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
   logic [31:0] g_pred  [7] = '{32'h304, 32'h304, 32'h304, 32'h304, 32'h380, 32'h304, 32'h380};
   logic        g_mis   [7] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};

   initial begin
      #100000;
      $display("FAIL timeout: simulation did not reach its end");
      $fatal(1, "timeout");
   end

   initial begin
      reset = 1'b1; fe_pc = 32'h100; upd_valid = 1'b0; upd_pc = '0;
      upd_is_cond = 1'b0; upd_is_jump = 1'b0; upd_taken = 1'b0;
      upd_target = '0; upd_pred_taken = 1'b0; upd_pred_pc = '0;
      repeat (2) @(posedge clk);
      #1 reset = 1'b0;
      #1;
      $display("reset released, lookup 0x100 -> %h", b_pred_pc);
      check("rst.taken", {31'd0, b_pred_taken}, 32'd0);
      check("rst.pc", b_pred_pc, 32'h104);
      check("rst.gpc", g_pred_pc, 32'h104);
      check("rst.bhr", {24'd0, b_bhr}, 32'd0);
      check("rst.br", b_stat_br, 32'd0);
      check("rst.mis", b_stat_mis, 32'd0);

      // JAL allocates a jump entry and leaves the history alone
      upd("jal", 32'h200, 1'b0, 1'b1, 32'h80, 32'h204, 1'b1, 32'h80);
      check("jal.smis", b_stat_mis, 32'd1);
      check("jal.sbr", b_stat_br, 32'd1);
      check("jal.bhr", {24'd0, b_bhr}, 32'd0);
      fe_pc = 32'h200;
      #1;
      check("jal.taken", {31'd0, b_pred_taken}, 32'd1);
      check("jal.pc", b_pred_pc, 32'h80);
      check("jal.gpc", g_pred_pc, 32'h80);

      // No update -> no mispredict, whatever the stale update fields say
      upd_pc = 32'h500; upd_taken = 1'b1; upd_target = 32'h999; upd_pred_pc = 32'h0;
      #1;
      check("idle.mis", {31'd0, b_mispredict}, 32'd0);

      // Bimodal training of the branch at 0x40
      fe_pc = 32'h40;
      upd("c1", 32'h40, 1'b1, 1'b1, 32'h10, 32'h44, 1'b1, 32'h10);
      check("c1.pc", b_pred_pc, 32'h10);
      upd("c2", 32'h40, 1'b1, 1'b1, 32'h10, 32'h10, 1'b0, 32'h10);
      upd("c3", 32'h40, 1'b1, 1'b1, 32'h10, 32'h10, 1'b0, 32'h10);
      upd("c4", 32'h40, 1'b1, 1'b1, 32'h10, 32'h10, 1'b0, 32'h10);
      check("c4.pc", b_pred_pc, 32'h10);
      upd("n1", 32'h40, 1'b1, 1'b0, 32'h10, 32'h10, 1'b1, 32'h44);
      check("n1.sat", b_pred_pc, 32'h10);
      upd("n2", 32'h40, 1'b1, 1'b0, 32'h10, 32'h10, 1'b1, 32'h44);
      check("n2.pc", b_pred_pc, 32'h44);
      check("n2.taken", {31'd0, b_pred_taken}, 32'd0);
      check("hist.bbhr", {24'd0, b_bhr}, 32'h3C);
      check("hist.gbhr", {30'd0, g_bhr}, 32'd0);
      check("hist.sbr", b_stat_br, 32'd7);
      check("hist.smis", b_stat_mis, 32'd4);

      // Same-cycle lookup and update: old prediction now, new one next cycle
      upd_valid = 1'b1; upd_pc = 32'h40; upd_is_cond = 1'b1; upd_is_jump = 1'b0;
      upd_taken = 1'b1; upd_target = 32'h10; upd_pred_pc = 32'h44; upd_pred_taken = 1'b0;
      #1;
      $display("upd same pc=00000040 taken=1 lookup=%h", b_pred_pc);
      check("same.old", b_pred_pc, 32'h44);
      @(posedge clk);
      #1 upd_valid = 1'b0;
      check("same.new", b_pred_pc, 32'h10);

      // Asynchronous reset between edges clears everything at once
      #2 reset = 1'b1;
      #1;
      $display("async reset asserted, lookup 0x40 -> %h", b_pred_pc);
      check("arst.pc", b_pred_pc, 32'h44);
      check("arst.taken", {31'd0, b_pred_taken}, 32'd0);
      check("arst.br", b_stat_br, 32'd0);
      check("arst.mis", b_stat_mis, 32'd0);
      check("arst.bhr", {24'd0, b_bhr}, 32'd0);
      // An update offered while reset is held must be ignored
      upd_valid = 1'b1; upd_pc = 32'h40; upd_is_cond = 1'b1; upd_is_jump = 1'b0;
      upd_taken = 1'b1; upd_target = 32'h10; upd_pred_pc = 32'h44;
      @(posedge clk);
      #1 upd_valid = 1'b0;
      @(negedge clk) reset = 1'b0;
      #1;
      check("arst.ign", b_stat_br, 32'd0);
      check("arst.ignpc", b_pred_pc, 32'h44);
      // From 01: T -> 10, N -> 01 gives not-taken; a stale 10 would stay taken
      upd("r1", 32'h40, 1'b1, 1'b1, 32'h10, 32'h44, 1'b1, 32'h10);
      upd("r2", 32'h40, 1'b1, 1'b0, 32'h10, 32'h10, 1'b1, 32'h44);
      check("arst.ctr", b_pred_pc, 32'h44);

      // Gshare phase on a fresh state
      reset = 1'b1;
      #1 reset = 1'b0;
      fe_pc = 32'h300;
      #1;
      for (int i = 0; i < 7; i++) begin
         check($sformatf("g%0d.look", i), g_pred_pc, g_pred[i]);
         upd($sformatf("g%0d", i), 32'h300, 1'b1, g_taken[i], 32'h380, g_pred[i],
             g_mis[i], g_taken[i] ? 32'h380 : 32'h304);
         check($sformatf("g%0d.bhr", i), {30'd0, g_bhr}, g_taken[i] ? 32'd1 : 32'd2);
      end
      check("g.smis", g_stat_mis, 32'd2);
      check("g.sbr", g_stat_br, 32'd7);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule

// File: doc/branch_predictor.md
# branch_predictor

Parametrised branch prediction unit for the five-stage RISC-V pipeline, generalising the BHR / pattern-table / BTB structures held in the execute stage into a standalone block. FE queries it combinationally each cycle with the fetch PC and receives a predicted next PC. AGEX drives one resolution update per cycle; the block trains its tables, reports mispredictions with a redirect PC, and keeps branch statistics. The block supports bimodal or gshare indexing, selected by parameter.

## Interface
- DBITS, 32: PC / target width.
- PT_IDX_BITS, 8: log2 of pattern-table entries (2-bit counters).
- BHR_BITS, 8: global history length. Must satisfy 1 ≤ BHR_BITS ≤ PT_IDX_BITS.
- BTB_IDX_BITS, 4: log2 of BTB entries (direct-mapped).
- GSHARE, 1: 1 = index is PC XOR BHR; 0 = bimodal (PC only, BHR still maintained).
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-high.
- fe_pc  in  DBITS  fetch PC to predict.
- fe_pred_taken  out  1  predicted taken.
- fe_pred_pc  out  DBITS  predicted next PC.
- upd_valid  in  1  resolution update this cycle.
- upd_pc  in  DBITS  PC of the resolved instruction.
- upd_is_cond  in  1  conditional branch (BEQ…BGEU).
- upd_is_jump  in  1  JAL/JALR. Exactly one of upd_is_cond and upd_is_jump is set when upd_valid=1.
- upd_taken  in  1  actual outcome (always 1 for jumps).
- upd_target  in  DBITS  actual taken target.
- upd_pred_taken  in  1  prediction carried down the pipe.
- upd_pred_pc  in  DBITS  predicted next PC carried down the pipe.
- mispredict  out  1  resolution disagrees with prediction.
- redirect_pc  out  DBITS  correct next PC.
- bhr_out  out  BHR_BITS  current history.
- stat_branches  out  32  count of updates.
- stat_mispredicts  out  32  count of mispredicts.

## Operation
- PC word index: pc[PT_IDX_BITS+1:2]. PT index = word index XOR {zero-extended BHR} when GSHARE=1; word index alone when GSHARE=0.
- BTB entry: valid, is_jump, tag = pc[DBITS-1:BTB_IDX_BITS+2], target. Index = pc[BTB_IDX_BITS+1:2].
- Lookup (combinational):
  - hit = valid & tag match.
  - fe_pred_taken = hit & (is_jump | counter[1]).
  - fe_pred_pc = fe_pred_taken ? btb target : fe_pc+4.
- Resolution (combinational from update inputs):
  - next = upd_taken ? upd_target : upd_pc+4.
  - mispredict = upd_valid & (next != upd_pred_pc).
  - redirect_pc = next.
- Update (clocked, when upd_valid=1):
  - Conditional branch: the PT counter at upd_pc's index, computed with the pre-update BHR, saturates up if taken and down if not taken (3 stays 3, 0 stays 0). The BHR then shifts to {bhr[BHR_BITS-2:0], upd_taken}.
  - Jump: PT and BHR are unchanged.
  - upd_taken=1: write the BTB entry as valid, with the tag, target, and is_jump=upd_is_jump (allocate or overwrite).
  - Not taken: the BTB is untouched.
  - stat_branches increments on every update. stat_mispredicts increments when mispredict=1. Both wrap modulo 2^32.
- Reset values:
  - PT counters: 2'b01 (weakly not-taken).
  - BTB valid bits: 0.
  - BHR: 0.
  - Statistics counters: 0.
  - Consequence: fe_pred_taken=0 and fe_pred_pc=fe_pc+4 after reset.

## Timing
- Lookup and resolution outputs have zero latency (combinational).
- Table updates become visible to lookups the cycle after upd_valid.
- Same-cycle lookup and update of the same entry: the lookup sees the old contents (no bypass).
- At most one update per cycle; no backpressure.
- Reset asserted mid-operation clears all state immediately. Updates during reset are ignored.
- upd_* inputs are don't-care when upd_valid=0. When upd_valid=0, mispredict must be 0.

## Test plan
- Reset, then fe_pc=0x100 → fe_pred_taken=0, fe_pred_pc=0x104; bhr_out=0; both stats=0.
- Apply a JAL update: pc=0x200, target=0x80, pred_pc=0x204 → mispredict=1, redirect_pc=0x80, stat_mispredicts=1. Next cycle, fe_pc=0x200 → taken, 0x80; BHR unchanged.
- GSHARE=0: three taken updates of cond branch pc=0x40→0x10. The first gives mispredict=1. Lookup then predicts taken to 0x10. Counter sits at 3; a fourth taken update keeps it saturated. Two not-taken updates then give a not-taken prediction (0x44).
- GSHARE=1, BHR_BITS=2: alternating T/N pattern on one branch. After warm-up, mispredicts stop incrementing. Verify bhr_out shifts correctly (e.g. 2'b10 after T,N).
- Lookup and update of the same PC in the same cycle → lookup returns the pre-update prediction; the next cycle returns the updated one.
- Assert reset between updates → BTB hits are lost, counters return to 01, and stats return to 0, all asynchronously before the next edge.
